isqrt_seq: RTL and testbench
============================

Name: isqrt_seq

Overview:
Parametrised sequential integer square root unit, successor to the fixed 8-bit square-root calculator. Uses the digit-by-digit (restoring) algorithm and retires one root bit per clock. Returns both floor(sqrt(a)) and the remainder a - sqrt^2. Has an explicit busy/valid handshake so a display or bus wrapper can sequence requests.

Parameters:
WIDTH, 8, radicand width in bits. Must be even and >= 2. H = WIDTH/2 is the root width and the iteration count.

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled on the rising edge, honoured only when not busy
a  input  WIDTH  unsigned radicand; captured on the accepted start edge
busy  output  1  high while an iteration is in progress
valid  output  1  high while sqrt/rem hold a completed result for the last accepted request
sqrt  output  H  floor(sqrt(a))
rem  output  H+1  a - sqrt*sqrt, range 0..2*sqrt

Behaviour:
- Reset (async, any time): state=IDLE, busy=0, valid=0, sqrt=0, rem=0, iteration counter=0, internal x/r/q registers=0. An operation in flight is abandoned; no result is produced.
- States:
  - IDLE: no result yet.
  - CALC: iterating.
  - DONE: result held.
- IDLE or DONE with start=1 on an edge:
  - load x<=a, r<=0, q<=0, count<=0
  - state->CALC, busy<=1, valid<=0
  - sqrt/rem keep their previous values; they are not meaningful while valid=0.
- CALC, each edge:
  - r' = (r<<2) | x[WIDTH-1:WIDTH-2]
  - x <= x<<2
  - t = r' - ((q<<2)|1)
  - if t >= 0: r<=t, q<=(q<<1)|1; else r<=r', q<=q<<1
  - Internal r/t width: H+2 bits plus sign.
  - count increments.
- On the H-th CALC edge:
  - sqrt<=final q, rem<=final r (truncated to H+1 bits, no loss)
  - busy<=0, valid<=1, state->DONE
- Latency: valid rises exactly H clock edges after the edge that accepted start (4 cycles for WIDTH=8). Throughput: one result per H+1 cycles with start held high.
- start in CALC is ignored: no restart, no queueing, and changes to a are ignored.
- start held high continuously: a new request is accepted on the first edge in DONE. valid is high for exactly one cycle between back-to-back results.
- DONE with start=0: outputs and valid hold indefinitely.
- a=0 -> sqrt=0, rem=0. Maximum a=2^WIDTH-1 -> sqrt=2^H-1, rem=2^(H+1)-2. No overflow at any width.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- WIDTH=8: reset pulse, then a=4 with a 1-cycle start -> busy high 4 cycles, then valid=1, sqrt=2, rem=0. Outputs hold until the next start.
- WIDTH=8: sequence a=100, then 49, then 0, then 255, each awaited -> (10,0), (7,0), (0,0), (15,30). valid is low during each CALC.
- WIDTH=8: a=50 started, then start=1 with a=81 pulsed on CALC cycle 2 -> the second request is ignored. Result is sqrt=7, rem=1, and busy drops after 4 cycles.
- WIDTH=8: start held high with a=200 -> results sqrt=14, rem=4 with valid high for 1 cycle every 5 cycles.
- WIDTH=8: assert reset asynchronously mid-CALC (between edges) for a=99 -> busy, valid, sqrt and rem go to 0 immediately. A subsequent start with a=99 gives sqrt=9, rem=18.
- WIDTH=16: a=65535 -> valid after 8 cycles, sqrt=255, rem=510. a=10000 -> sqrt=100, rem=0. Random sweep checked against a reference model: sqrt^2 <= a < (sqrt+1)^2 and rem = a - sqrt^2.

Source files
------------

// File: rtl/isqrt_seq_if.sv
// ============================================================================
// Module      : isqrt_seq_if
// Description : Request/result bundle for the sequential integer square root.
//               The requester drives start/a; the root unit returns
//               busy/valid and the registered sqrt/rem result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface isqrt_seq_if #(
  parameter int WIDTH = 8
);
  localparam int c_H = WIDTH / 2;

  logic             start;
  logic [WIDTH-1:0] a;
  logic             busy;
  logic             valid;
  logic [c_H-1:0]   sqrt;
  logic [c_H:0]     rem;

  modport master (output start, output a,
                  input  busy,  input  valid, input sqrt, input rem);
  modport slave  (input  start, input  a,
                  output busy,  output valid, output sqrt, output rem);
endinterface

`default_nettype wire

// File: rtl/isqrt_seq.sv
// ============================================================================
// Module      : isqrt_seq
// Description : Sequential restoring (digit-by-digit) integer square root.
//               Retires one root bit per clock, WIDTH/2 iterations per
//               request, returns floor(sqrt(a)) and a - sqrt^2.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module isqrt_seq #(
  parameter int WIDTH = 8
) (
  input  wire logic   clk,
  input  wire logic   reset,
  isqrt_seq_if.slave  bus
);

  localparam int c_H  = WIDTH / 2;
  localparam int c_CW = (c_H > 1) ? $clog2(c_H) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(c_H - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_accept;
  logic              w_last;

  logic [WIDTH-1:0]  r_x;
  logic [c_H+1:0]    r_r;
  logic [c_H-1:0]    r_q;
  logic [c_CW-1:0]   r_count;
  logic              r_busy;
  logic              r_valid;
  logic [c_H-1:0]    r_sqrt;
  logic [c_H:0]      r_rem;

  logic [c_H+1:0]    w_rp;
  logic [c_H+2:0]    w_t;
  logic [c_H+1:0]    w_rnext;
  logic [c_H-1:0]    w_qnext;

  // One restoring step: bring down the next radicand digit pair and try
  // subtracting 4q+1; the sign of the trial decides the new root bit.
  // The partial remainder never exceeds 2q, so the top two bits shifted
  // out of r are always zero.
  always_comb begin
    w_rp = (r_r << 2) | (c_H+2)'(r_x[WIDTH-1:WIDTH-2]);
    w_t  = {1'b0, w_rp} - {1'b0, r_q, 2'b01};
    if (!w_t[c_H+2]) begin
      w_rnext = w_t[c_H+1:0];
      w_qnext = (r_q << 1) | c_H'(1);
    end else begin
      w_rnext = w_rp;
      w_qnext = r_q << 1;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode: accept in IDLE/DONE, finish on the last iteration.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = S_CALC;
        end
      end
      S_CALC: begin
        if (r_count == c_LAST) begin
          w_last = 1'b1;
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; sqrt/rem only change on completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x     <= '0;
      r_r     <= '0;
      r_q     <= '0;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_sqrt  <= '0;
      r_rem   <= '0;
    end else if (w_accept) begin
      r_x     <= bus.a;
      r_r     <= '0;
      r_q     <= '0;
      r_count <= '0;
      r_busy  <= 1'b1;
      r_valid <= 1'b0;
    end else if (r_state == S_CALC) begin
      r_x     <= r_x << 2;
      r_r     <= w_rnext;
      r_q     <= w_qnext;
      r_count <= r_count + c_CW'(1);
      if (w_last) begin
        r_sqrt  <= w_qnext;
        r_rem   <= w_rnext[c_H:0];
        r_busy  <= 1'b0;
        r_valid <= 1'b1;
      end
    end
  end

  assign bus.busy  = r_busy;
  assign bus.valid = r_valid;
  assign bus.sqrt  = r_sqrt;
  assign bus.rem   = r_rem;

endmodule

`default_nettype wire

// File: tb/tb_isqrt_seq.sv
// ============================================================================
// Module      : tb_isqrt_seq
// Description : Self-checking bench for isqrt_seq at WIDTH=8 and WIDTH=16.
//               A cycle-level behavioural model predicts busy/valid/sqrt/rem
//               from plain arithmetic; directed vectors pin literal results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_isqrt_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  isqrt_seq_if #(.WIDTH(8))  b8 ();
  isqrt_seq_if #(.WIDTH(16)) b16 ();

  isqrt_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(rst), .bus(b8));
  isqrt_seq #(.WIDTH(16)) dut16 (.clk(clk), .reset(rst), .bus(b16));

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Floor square root by plain search.
  function automatic longint isq(input longint v);
    longint s = 0;
    while ((s + 1) * (s + 1) <= v) s++;
    return s;
  endfunction

  // Behavioural model: a request accepted when idle completes H edges later.
  logic   m8_busy = 0, m8_valid = 0;
  longint m8_sqrt = 0, m8_rem = 0, m8_a = 0;
  int     m8_left = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m8_busy = 0; m8_valid = 0; m8_sqrt = 0; m8_rem = 0; m8_left = 0;
    end else if (!m8_busy && b8.start) begin
      m8_busy = 1; m8_valid = 0; m8_a = longint'(b8.a); m8_left = 4;
    end else if (m8_busy) begin
      m8_left--;
      if (m8_left == 0) begin
        m8_busy = 0; m8_valid = 1;
        m8_sqrt = isq(m8_a); m8_rem = m8_a - m8_sqrt * m8_sqrt;
      end
    end
  end

  logic   m16_busy = 0, m16_valid = 0;
  longint m16_sqrt = 0, m16_rem = 0, m16_a = 0;
  int     m16_left = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m16_busy = 0; m16_valid = 0; m16_sqrt = 0; m16_rem = 0; m16_left = 0;
    end else if (!m16_busy && b16.start) begin
      m16_busy = 1; m16_valid = 0; m16_a = longint'(b16.a); m16_left = 8;
    end else if (m16_busy) begin
      m16_left--;
      if (m16_left == 0) begin
        m16_busy = 0; m16_valid = 1;
        m16_sqrt = isq(m16_a); m16_rem = m16_a - m16_sqrt * m16_sqrt;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy8",   b8.busy,   m8_busy);
      chk("valid8",  b8.valid,  m8_valid);
      chk("sqrt8",   b8.sqrt,   m8_sqrt);
      chk("rem8",    b8.rem,    m8_rem);
      chk("busy16",  b16.busy,  m16_busy);
      chk("valid16", b16.valid, m16_valid);
      chk("sqrt16",  b16.sqrt,  m16_sqrt);
      chk("rem16",   b16.rem,   m16_rem);
    end
  end

  function automatic logic vld(input bit w);
    return w ? b16.valid : b8.valid;
  endfunction

  function automatic logic bsy(input bit w);
    return w ? b16.busy : b8.busy;
  endfunction

  task automatic go(input bit w, input int v);
    @(negedge clk);
    if (w) begin b16.a = 16'(v); b16.start = 1'b1; end
    else   begin b8.a  = 8'(v);  b8.start  = 1'b1; end
    @(negedge clk);
    b8.start  = 1'b0;
    b16.start = 1'b0;
  endtask

  task automatic wait_valid(input bit w, input string nm);
    int n = 0;
    while (!vld(w) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_timeout"}, vld(w), 1);
  endtask

  task automatic result(input bit w, input string nm, input int es, input int er);
    if (w) begin
      chk({nm, "_sqrt"}, b16.sqrt, es);
      chk({nm, "_rem"},  b16.rem,  er);
    end else begin
      chk({nm, "_sqrt"}, b8.sqrt, es);
      chk({nm, "_rem"},  b8.rem,  er);
    end
  endtask

  int ta[4] = '{100, 49, 0, 255};
  int ts[4] = '{10, 7, 0, 15};
  int tr[4] = '{0, 0, 0, 30};

  initial begin
    int n, nv, first, last;
    int v;
    b8.start = 0;  b8.a = '0;
    b16.start = 0; b16.a = '0;

    // Pin the model against hand-computed roots.
    chk("model_isq255",   isq(255), 15);
    chk("model_isq99",    isq(99), 9);
    chk("model_isq65535", isq(65535), 255);

    #1 rst = 1'b1;
    #2;
    chk("rst_busy",  b8.busy, 0);
    chk("rst_valid", b8.valid, 0);
    chk("rst_sqrt",  b8.sqrt, 0);
    chk("rst_rem",   b8.rem, 0);
    chk("rst_valid16", b16.valid, 0);
    #10 rst = 1'b0;

    // a=4: busy for 4 cycles, then result held.
    go(0, 4);
    n = 0;
    while (bsy(0) && n < 30) begin @(negedge clk); n++; end
    chk("busy_cycles8", n, 4);
    wait_valid(0, "a4");
    result(0, "a4", 2, 0);
    repeat (3) @(negedge clk);
    chk("a4_hold_valid", b8.valid, 1);
    result(0, "a4_hold", 2, 0);

    // Directed table.
    for (int i = 0; i < 4; i++) begin
      go(0, ta[i]);
      chk("tab_valid_low", b8.valid, 0);
      wait_valid(0, "tab");
      result(0, "tab", ts[i], tr[i]);
    end

    // Second start during CALC is ignored.
    go(0, 50);
    b8.a = 8'd81; b8.start = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    wait_valid(0, "ign");
    result(0, "ign", 7, 1);
    repeat (2) @(negedge clk);
    chk("ign_no_restart", b8.busy, 0);
    chk("ign_still_valid", b8.valid, 1);

    // Start held high: one-cycle valid every 5 cycles.
    @(negedge clk);
    b8.a = 8'd200; b8.start = 1'b1;
    nv = 0; first = -1; last = -1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (b8.valid) begin
        nv++;
        if (first < 0) first = i;
        last = i;
        result(0, "held", 14, 4);
      end
    end
    b8.start = 1'b0;
    chk("held_count", nv, 3);
    chk("held_period", last - first, 10);
    wait_valid(0, "held_end");

    // Async reset mid-calculation.
    go(0, 99);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy",  b8.busy, 0);
    chk("arst_valid", b8.valid, 0);
    chk("arst_sqrt",  b8.sqrt, 0);
    chk("arst_rem",   b8.rem, 0);
    #1 rst = 1'b0;
    go(0, 99);
    wait_valid(0, "a99");
    result(0, "a99", 9, 18);

    // WIDTH=16.
    go(1, 65535);
    n = 0;
    while (bsy(1) && n < 30) begin @(negedge clk); n++; end
    chk("busy_cycles16", n, 8);
    wait_valid(1, "max16");
    result(1, "max16", 255, 510);
    go(1, 10000);
    wait_valid(1, "a10000");
    result(1, "a10000", 100, 0);

    for (int i = 0; i < 20; i++) begin
      v = int'($urandom_range(0, 65535));
      go(1, v);
      wait_valid(1, "sweep");
      chk("sweep_lo", (longint'(b16.sqrt) * longint'(b16.sqrt) <= longint'(v)), 1);
      chk("sweep_hi", (longint'(v) < (longint'(b16.sqrt) + 1) * (longint'(b16.sqrt) + 1)), 1);
      chk("sweep_rem", b16.rem, 64'(longint'(v) - longint'(b16.sqrt) * longint'(b16.sqrt)));
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
